// File: rtl/instr_fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
package instr_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] PC_INC           = 32'd4;

  // Force a PC onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Bundle of the instruction-memory bus, redirect input and decode-side handshake.
interface instr_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;

  // Fetch stage side.
  modport master (
    output imem_req, imem_addr, out_valid, out_instr, out_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

  // Environment side: instruction memory plus decode/redirect source.
  modport slave (
    input  imem_req, imem_addr, out_valid, out_instr, out_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, out_ready
  );

endinterface

// File: rtl/instr_fetch_fifo.sv
// Synchronous word FIFO between instruction memory and decode; flush wins over push/pop.
module instr_fetch_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [31:0]              wdata_i,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [31:0]              head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Next pointer/count values; flush empties the FIFO regardless of push/pop.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage; cleared on reset so the head reads zero until the first word lands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (push_i && !flush_i) begin
      mem_q[wr_ptr_q] <= wdata_i;
    end
  end

  // Overflow/underflow can only come from a broken caller.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(push_i && count_q == CW'(DEPTH)));
      assert (!(pop_i && count_q == '0));
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: owns the fetch PC, issues word requests, buffers
// returned words and hands {instr, pc} to decode; redirects flush and drop stale data.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int unsigned DEPTH    = 4
) (
  input logic           clk,
  input logic           rst,
  instr_fetch_if.master bus
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned OW = CW + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   deliver_pc_q, deliver_pc_d;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [CW-1:0] fifo_count;
  logic [31:0]   fifo_head;
  logic [OW-1:0] occupancy;
  logic          out_valid;
  logic          imem_req;
  logic          pop;
  logic          push;
  logic          gnt_fire;
  logic          rvalid_ok;

  // Handshake decode and next-state for counters and PCs.
  always_comb begin
    out_valid = (fifo_count != '0) && !bus.redirect_valid;
    pop       = out_valid && bus.out_ready;
    // Slots already committed (in flight + buffered) after this cycle's pop.
    occupancy = {1'b0, inflight_q} + {1'b0, fifo_count} - OW'(pop);
    imem_req  = !rst && !bus.redirect_valid && (occupancy < OW'(DEPTH));
    gnt_fire  = imem_req && bus.imem_gnt;
    // A response with nothing outstanding is a protocol error and is ignored.
    rvalid_ok = bus.imem_rvalid && (inflight_q != '0);
    push      = rvalid_ok && (discard_q == '0) && !bus.redirect_valid;

    inflight_d   = inflight_q + CW'(gnt_fire) - CW'(rvalid_ok);
    discard_d    = discard_q;
    fetch_pc_d   = fetch_pc_q;
    deliver_pc_d = deliver_pc_q;

    if (bus.redirect_valid) begin
      // Everything still outstanding after this cycle's response is stale.
      discard_d    = inflight_q - CW'(rvalid_ok);
      fetch_pc_d   = align_pc(bus.redirect_pc);
      deliver_pc_d = align_pc(bus.redirect_pc);
    end else begin
      if (rvalid_ok && discard_q != '0) discard_d = discard_q - CW'(1);
      if (gnt_fire) fetch_pc_d   = fetch_pc_q + PC_INC;
      if (pop)      deliver_pc_d = deliver_pc_q + PC_INC;
    end
  end

  // Architectural PCs and request bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q   <= RESET_PC;
      deliver_pc_q <= RESET_PC;
      inflight_q   <= '0;
      discard_q    <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      deliver_pc_q <= deliver_pc_d;
      inflight_q   <= inflight_d;
      discard_q    <= discard_d;
    end
  end

  instr_fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (bus.redirect_valid),
    .wdata_i (bus.imem_rdata),
    .count_o (fifo_count),
    .head_o  (fifo_head)
  );

  // Responses must always match an outstanding request.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(bus.imem_rvalid && inflight_q == '0));
  end

  assign bus.imem_req  = imem_req;
  assign bus.imem_addr = fetch_pc_q;
  assign bus.out_valid = out_valid;
  assign bus.out_instr = fifo_head;
  assign bus.out_pc    = deliver_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_if bus ();
  instr_fetch_if bus2 ();

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut2 (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_chk  = 0;
  int n_fail = 0;
  int n_gnt  = 0;
  bit hold   = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] pend2[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hCAFE_F00D;
  endfunction

  task automatic clear_inputs();
    bus.imem_gnt = 1'b0;  bus.imem_rvalid = 1'b0;  bus.imem_rdata = '0;
    bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;  bus.out_ready = 1'b0;
    bus2.imem_gnt = 1'b0; bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    bus2.redirect_valid = 1'b0; bus2.redirect_pc = '0; bus2.out_ready = 1'b0;
  endtask

  // One clock: record grants, then drive 1-cycle-latency in-order responses.
  task automatic tick();
    if (bus.imem_req && bus.imem_gnt) begin
      pend.push_back(bus.imem_addr);
      n_gnt++;
    end
    if (bus2.imem_req && bus2.imem_gnt) pend2.push_back(bus2.imem_addr);
    @(posedge clk);
    #1;
    bus.imem_rvalid = 1'b0;  bus.imem_rdata = '0;
    bus2.imem_rvalid = 1'b0; bus2.imem_rdata = '0;
    if (!hold && pend.size() > 0) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = mem_word(pend.pop_front());
    end
    if (pend2.size() > 0) begin
      bus2.imem_rvalid = 1'b1;
      bus2.imem_rdata  = mem_word(pend2.pop_front());
    end
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    clear_inputs();
    hold = 1'b0;
    pend.delete();
    pend2.delete();
    n_gnt = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    #2;
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", bus.imem_req); end
    n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    n_chk++; if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr got %h want 0", bus.out_instr); end
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr got %h want 0", bus.imem_addr); end
    n_chk++; if (bus2.imem_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("FAIL reset_addr2 got %h want fffffff8", bus2.imem_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL release_req got %b/%h want 1/00000000", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_stream();
    apply_reset();
    bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*k)) begin n_fail++; $display("FAIL stream_addr c%0d got %b/%h want 1/%h", k, bus.imem_req, bus.imem_addr, 32'(4*k)); end
      if (k >= 2) begin
        n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4*(k-2)) || bus.out_instr !== mem_word(32'(4*(k-2)))) begin
          n_fail++; $display("FAIL stream_out c%0d got %b/%h/%h want 1/%h/%h", k, bus.out_valid, bus.out_pc, bus.out_instr, 32'(4*(k-2)), mem_word(32'(4*(k-2))));
        end
      end else begin
        n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid c%0d got %b want 0", k, bus.out_valid); end
      end
      tick();
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
    #1;
    repeat (5) tick();
    n_chk++; if (n_gnt !== 4) begin n_fail++; $display("FAIL bp_grants got %0d want 4", n_gnt); end
    n_chk++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_stop got %b want 0", bus.imem_req); end
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head got %b/%h want 1/00000000", bus.out_valid, bus.out_pc); end
    bus.out_ready = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h10) begin n_fail++; $display("FAIL bp_resume got %b/%h want 1/00000010", bus.imem_req, bus.imem_addr); end
    for (int k = 0; k < 5; k++) begin
      n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4*k) || bus.out_instr !== mem_word(32'(4*k))) begin
        n_fail++; $display("FAIL bp_drain k%0d got %b/%h/%h want 1/%h/%h", k, bus.out_valid, bus.out_pc, bus.out_instr, 32'(4*k), mem_word(32'(4*k)));
      end
      tick();
    end
  endtask

  task automatic test_gnt_stall();
    apply_reset();
    bus.imem_gnt = 1'b0; bus.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL stall_hold c%0d got %b/%h want 1/00000000", k, bus.imem_req, bus.imem_addr); end
      tick();
    end
    bus.imem_gnt = 1'b1;
    #1;
    n_chk++; if (bus.imem_addr !== 32'h0) begin n_fail++; $display("FAIL stall_gnt_addr got %h want 00000000", bus.imem_addr); end
    tick();
    n_chk++; if (bus.imem_addr !== 32'h4) begin n_fail++; $display("FAIL stall_advance got %h want 00000004", bus.imem_addr); end
    tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL stall_out got %b/%h/%h want 1/00000000/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_word(32'h0));
    end
  endtask

  task automatic test_redirect_flush();
    apply_reset();
    bus.imem_gnt = 1'b1; bus.out_ready = 1'b0;
    #1;
    tick();
    tick();
    hold = 1'b1;
    tick();
    tick();
    n_chk++; if (bus.imem_req !== 1'b0 || bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0) begin
      n_fail++; $display("FAIL rf_setup got req %b valid %b pc %h want 0/1/00000000", bus.imem_req, bus.out_valid, bus.out_pc);
    end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40; hold = 1'b0;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rf_redirect_cycle got valid %b req %b want 0/0", bus.out_valid, bus.imem_req); end
    tick();
    bus.redirect_valid = 1'b0; bus.out_ready = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL rf_new_addr got %b/%h want 1/00000040", bus.imem_req, bus.imem_addr); end
    for (int k = 0; k < 3; k++) begin
      n_chk++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rf_stale_valid c%0d got %b/%h/%h want 0", k + 5, bus.out_valid, bus.out_pc, bus.out_instr); end
      tick();
    end
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== mem_word(32'h40)) begin
      n_fail++; $display("FAIL rf_first got %b/%h/%h want 1/00000040/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_word(32'h40));
    end
    tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h44 || bus.out_instr !== mem_word(32'h44)) begin
      n_fail++; $display("FAIL rf_second got %b/%h/%h want 1/00000044/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_word(32'h44));
    end
  endtask

  task automatic test_redirect_rvalid();
    apply_reset();
    bus.imem_gnt = 1'b1; bus.out_ready = 1'b1;
    #1;
    repeat (3) tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h4) begin n_fail++; $display("FAIL rr_setup got %b/%h want 1/00000004", bus.out_valid, bus.out_pc); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h43;
    #1;
    n_chk++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rr_redirect_cycle got valid %b req %b want 0/0", bus.out_valid, bus.imem_req); end
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin n_fail++; $display("FAIL rr_new_addr got %b/%h want 1/00000040", bus.imem_req, bus.imem_addr); end
    n_chk++; if (bus.out_valid !== 1'b0 || bus.out_pc !== 32'h40) begin n_fail++; $display("FAIL rr_deliver_pc got %b/%h want 0/00000040", bus.out_valid, bus.out_pc); end
    tick();
    tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h40 || bus.out_instr !== mem_word(32'h40)) begin
      n_fail++; $display("FAIL rr_first got %b/%h/%h want 1/00000040/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_word(32'h40));
    end
  endtask

  task automatic test_wrap();
    logic [31:0] wexp [6];
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    apply_reset();
    bus2.imem_gnt = 1'b1; bus2.out_ready = 1'b1;
    #1;
    for (int k = 0; k < 6; k++) begin
      n_chk++; if (bus2.imem_req !== 1'b1 || bus2.imem_addr !== wexp[k]) begin n_fail++; $display("FAIL wrap_addr c%0d got %b/%h want 1/%h", k, bus2.imem_req, bus2.imem_addr, wexp[k]); end
      if (k >= 2) begin
        n_chk++; if (bus2.out_valid !== 1'b1 || bus2.out_pc !== wexp[k-2] || bus2.out_instr !== mem_word(wexp[k-2])) begin
          n_fail++; $display("FAIL wrap_out c%0d got %b/%h/%h want 1/%h/%h", k, bus2.out_valid, bus2.out_pc, bus2.out_instr, wexp[k-2], mem_word(wexp[k-2]));
        end
      end
      tick();
    end
    bus2.imem_gnt = 1'b0; bus2.out_ready = 1'b0;
  endtask

  task automatic test_reset_midstream();
    apply_reset();
    bus.imem_gnt = 1'b1; bus.out_ready = 1'b0; hold = 1'b1;
    #1;
    repeat (3) tick();
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'hC) begin n_fail++; $display("FAIL mid_setup got %b/%h want 1/0000000c", bus.imem_req, bus.imem_addr); end
    rst = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b0 || bus.imem_addr !== 32'h0 || bus.out_valid !== 1'b0 || bus.out_instr !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset got req %b addr %h valid %b instr %h want 0/00000000/0/00000000", bus.imem_req, bus.imem_addr, bus.out_valid, bus.out_instr);
    end
    pend.delete();
    hold = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.imem_rvalid = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    n_chk++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0 || bus.out_valid !== 1'b0) begin
      n_fail++; $display("FAIL mid_release got %b/%h valid %b want 1/00000000/0", bus.imem_req, bus.imem_addr, bus.out_valid);
    end
    tick();
    tick();
    n_chk++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h0 || bus.out_instr !== mem_word(32'h0)) begin
      n_fail++; $display("FAIL mid_first got %b/%h/%h want 1/00000000/%h", bus.out_valid, bus.out_pc, bus.out_instr, mem_word(32'h0));
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_gnt_stall();
    test_redirect_flush();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Instruction-fetch stage directly upstream of the CPU decode/execute loop; owns the architectural fetch PC.
- Issues word requests to instruction memory over a req/gnt + rvalid interface and buffers returned words in a small FIFO.
- Delivers {instruction, PC} pairs to decode over a valid/ready handshake.
- Accepts redirects (jump/branch/trap) from downstream: flushes buffered words and drops stale in-flight responses.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- DEPTH, 4, FIFO entries and maximum in-flight requests; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  word-aligned fetch address; bits [1:0] always 0.
- imem_gnt  in  1  request accepted this cycle; meaningful only while imem_req=1.
- imem_rvalid  in  1  read data valid; responses return in request order.
- imem_rdata  in  32  instruction word.
- redirect_valid  in  1  change fetch stream this cycle.
- redirect_pc  in  32  new PC; bits [1:0] ignored and forced to 0.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts this cycle.
- out_instr  out  32  instruction at FIFO head.
- out_pc  out  32  PC of out_instr.

Behaviour:
- Reset (asynchronous):
  - fetch_pc=RESET_PC, deliver_pc=RESET_PC.
  - inflight_cnt=0, discard_cnt=0, FIFO empty.
  - out_valid=0, imem_req=0, out_instr=0.
- pop = out_valid & out_ready.
- Issue rule:
  - imem_req = !redirect_valid & (inflight_cnt + fifo_count − pop < DEPTH).
  - imem_addr = fetch_pc.
  - Once imem_req=1 without gnt, imem_addr stays stable until gnt. The only exception is a redirect: that cycle forces imem_req=0, and the new address appears next cycle.
- On imem_req & imem_gnt: fetch_pc += 4 (modulo 2^32, 32'hFFFF_FFFC wraps to 0), inflight_cnt += 1.
- On imem_rvalid:
  - inflight_cnt −= 1.
  - If discard_cnt>0: word dropped, discard_cnt −= 1.
  - Otherwise: word pushed into FIFO at the clock edge.
  - Simultaneous gnt and rvalid leave inflight_cnt unchanged.
- Output:
  - out_valid = (fifo_count!=0) & !redirect_valid.
  - out_instr = FIFO head; out_pc = deliver_pc.
  - No bypass: the earliest out_valid is the cycle after the rvalid.
- On pop: FIFO head removed, deliver_pc += 4.
- Latency: req+gnt in cycle N, rvalid in N+1, out_valid in N+2. DEPTH=4 sustains 1 instruction/cycle at 1-cycle memory latency.
- Redirect cycle (redirect_valid=1):
  - Next cycle: fetch_pc = deliver_pc = {redirect_pc[31:2],2'b00}.
  - FIFO flushed.
  - discard_cnt <= inflight_cnt − rvalid_this_cycle; a response arriving in the redirect cycle is itself dropped.
  - out_valid forced 0, so no pop occurs in the redirect cycle.
  - imem_req forced 0, so no gnt is sampled.
- Back-to-back redirects: the last one wins. discard_cnt is recomputed each time and covers every request still in flight.
- FIFO full: issue rule guarantees no overflow; an rvalid with a full FIFO is unreachable (assertion).
- rvalid with inflight_cnt=0 is a protocol error: the word is dropped, counters saturate at 0, and a simulation assertion fires.
- The instruction memory shares rst; after reset release every response belongs to a post-reset request.
- Reset mid-stream: all counters, the FIFO and PCs return to reset values immediately; the first request is RESET_PC in the first cycle after release.

Decomposition:
- Shared defines file gains:
  - `RESET_PC default.
  - `NOP_INSTR (32'h0000_0013).
  - Fetch PC increment constant (4).
- Sub-module fetch_fifo:
  - Synchronous FIFO, DEPTH entries × 32 bits.
  - Ports push, pop, flush, count, head.
  - Flush has priority over push/pop in the same cycle.
- Counters and PC logic stay in instr_fetch.

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid returning mem[addr>>2] -> addresses 0x0,0x4,0x8,...; out_valid from cycle 2; out_pc 0x0,0x4,0x8 with matching words, one per cycle.
- out_ready=0 from start -> exactly 4 requests granted, then imem_req=0; FIFO holds words for 0x0..0xC; raising out_ready resumes requests at 0x10.
- imem_gnt=0 for 3 cycles on the first request -> imem_req=1 and imem_addr=0x0 stable throughout; fetch_pc advances only after gnt.
- 2 requests in flight (0x8, 0xC) plus 2 words buffered, redirect to 0x40 -> FIFO empty; both late responses dropped; next outputs pc 0x40,0x44; no 0x8/0xC word reaches out_instr.
- Redirect to 0x43 in the same cycle as an rvalid and out_ready=1 -> no pop; arriving word dropped; next imem_addr=0x40; next out_pc=0x40.
- RESET_PC=32'hFFFF_FFF8 -> fetch addresses 0xFFFFFFF8,0xFFFFFFFC,0x0; out_pc sequence wraps identically.
- Assert rst while 3 requests are in flight -> all outputs at reset values immediately; after release the first request is RESET_PC with no stale data delivered.
